// File: rtl/mac_pkg.sv
// mac_pkg: shared types and sizing helpers for the sequential MAC.
//   state_e   : handshake FSM states (IDLE -> RUN -> ACC -> IDLE)
//   cnt_width : width of the multiplier iteration counter for a given operand width
package mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ACC  = 2'd2
  } state_e;

  // Counter must hold 0..W.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mac_seq_if.sv
// mac_seq_if: request/result bundle between a datapath sequencer and mac_seq.
//   master (sequencer): drives start, opa, opb, signed_mode, acc_clr; reads busy, done, out, ovf
//   slave  (mac_seq)  : the mirror image
interface mac_seq_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 2 * W + 4
) ();

  logic             start;
  logic [W-1:0]     opa;
  logic [W-1:0]     opb;
  logic             signed_mode;
  logic             acc_clr;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] out;
  logic             ovf;

  modport master (
    output start, opa, opb, signed_mode, acc_clr,
    input  busy, done, out, ovf
  );

  modport slave (
    input  start, opa, opb, signed_mode, acc_clr,
    output busy, done, out, ovf
  );

endinterface

// File: rtl/mac_mul_core.sv
// mac_mul_core: unsigned shift-add multiplier, one multiplier bit per clock, LSB first.
//   clk, clr   : clock, async active-high reset
//   load       : capture mcand_in/mplier_in, clear product and counter
//   step       : process one multiplier bit
//   mcand_in   : W-bit multiplicand magnitude
//   mplier_in  : W-bit multiplier magnitude
//   prod       : 2W-bit registered partial/final product
//   last_c     : current step is the final (W-th) iteration
module mac_mul_core
  import mac_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   mcand_in,
  input  logic [W-1:0]   mplier_in,
  output logic [2*W-1:0] prod,
  output logic           last_c
);

  localparam int unsigned CNT_W = cnt_width(W);

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Multiplicand is pre-shifted each step so the add is always mcand << i.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = (2*W)'(mcand_in);
      mplier_d = mplier_in;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign prod   = prod_q;
  assign last_c = (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/mac_seq.sv
// mac_seq: sequential multiply-accumulate with per-op signed mode, saturation and sticky overflow.
//   clk, clr : clock, async active-high reset
//   bus      : slave side of mac_seq_if (start/opa/opb/signed_mode/acc_clr in; busy/done/out/ovf out)
//   W        : operand width; ACC_W: accumulator width; SAT: 1 clamp on overflow, 0 wrap
module mac_seq
  import mac_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 2 * W + 4,
  parameter bit          SAT   = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  mac_seq_if.slave   bus
);

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0]     mag_a_c, mag_b_c;
  logic [2*W-1:0]   prod_c;
  logic             last_c;
  logic             load_c;

  logic [ACC_W-1:0] addend_c, base_c, sat_c, res_c;
  logic [ACC_W:0]   sum_c;
  logic             ovf_c;

  // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits.
  always_comb begin
    mag_a_c = (bus.signed_mode && bus.opa[W-1]) ? (~bus.opa + W'(1)) : bus.opa;
    mag_b_c = (bus.signed_mode && bus.opb[W-1]) ? (~bus.opb + W'(1)) : bus.opb;
  end

  assign load_c = (state_q == S_IDLE) && bus.start;

  mac_mul_core #(.W(W)) u_core (
    .clk       (clk),
    .clr       (clr),
    .load      (load_c),
    .step      (state_q == S_RUN),
    .mcand_in  (mag_a_c),
    .mplier_in (mag_b_c),
    .prod      (prod_c),
    .last_c    (last_c)
  );

  // Accumulate with overflow detection and optional clamp; acc_clr turns it into a load.
  always_comb begin
    addend_c = sign_q ? (ACC_W'(0) - ACC_W'(prod_c)) : ACC_W'(prod_c);
    base_c   = bus.acc_clr ? '0 : out_q;
    sum_c    = {1'b0, base_c} + {1'b0, addend_c};
    if (mode_q)
      ovf_c = (base_c[ACC_W-1] == addend_c[ACC_W-1]) && (sum_c[ACC_W-1] != base_c[ACC_W-1]);
    else
      ovf_c = sum_c[ACC_W];
    if (!mode_q)              sat_c = '1;
    else if (addend_c[ACC_W-1]) sat_c = {1'b1, {(ACC_W-1){1'b0}}};
    else                      sat_c = {1'b0, {(ACC_W-1){1'b1}}};
    res_c = (ovf_c && SAT) ? sat_c : sum_c[ACC_W-1:0];
  end

  // Handshake FSM and result registers.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    ovf_d   = ovf_q;

    if (bus.acc_clr) begin
      out_d = '0;
      ovf_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          mode_d  = bus.signed_mode;
          sign_d  = bus.signed_mode & (bus.opa[W-1] ^ bus.opb[W-1]);
        end
      end
      S_RUN: begin
        if (last_c) state_d = S_ACC;
      end
      S_ACC: begin
        out_d   = res_c;
        ovf_d   = bus.acc_clr ? ovf_c : (ovf_q | ovf_c);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed self-checking bench for mac_seq (W=8; ACC_W=20 SAT=1 main unit,
// plus two ACC_W=16 units with SAT=1 and SAT=0 for overflow behaviour).
module tb_mac_seq;

  logic clk = 1'b0;
  logic clr;

  int n_tests = 0;
  int n_fail  = 0;

  mac_seq_if #(.W(8), .ACC_W(20)) m_if ();
  mac_seq_if #(.W(8), .ACC_W(16)) s_if ();
  mac_seq_if #(.W(8), .ACC_W(16)) w_if ();

  mac_seq #(.W(8), .ACC_W(20), .SAT(1'b1)) dut_m (.clk(clk), .clr(clr), .bus(m_if.slave));
  mac_seq #(.W(8), .ACC_W(16), .SAT(1'b1)) dut_s (.clk(clk), .clr(clr), .bus(s_if.slave));
  mac_seq #(.W(8), .ACC_W(16), .SAT(1'b0)) dut_w (.clk(clk), .clr(clr), .bus(w_if.slave));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    m_if.start = 0; m_if.opa = 0; m_if.opb = 0; m_if.signed_mode = 0; m_if.acc_clr = 0;
    s_if.start = 0; s_if.opa = 0; s_if.opb = 0; s_if.signed_mode = 0; s_if.acc_clr = 0;
    w_if.start = 0; w_if.opa = 0; w_if.opb = 0; w_if.signed_mode = 0; w_if.acc_clr = 0;
  endtask

  // Issue one op on the main unit; lat = edges from accept to done, -1 on timeout.
  task automatic run_main(input logic [7:0] a, input logic [7:0] b, input logic sm, output int lat);
    m_if.start = 1; m_if.opa = a; m_if.opb = b; m_if.signed_mode = sm;
    tick;
    m_if.start = 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (m_if.done) begin lat = i; break; end
    end
  endtask

  // Same op on both 16-bit units.
  task automatic run_16(input logic [7:0] a, input logic [7:0] b, output int lat);
    s_if.start = 1; s_if.opa = a; s_if.opb = b; s_if.signed_mode = 0;
    w_if.start = 1; w_if.opa = a; w_if.opb = b; w_if.signed_mode = 0;
    tick;
    s_if.start = 0; w_if.start = 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (s_if.done && w_if.done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    clr = 1;
    drive_idle();
    tick;
    n_tests++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", m_if.busy); end
    n_tests++; if (m_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", m_if.done); end
    n_tests++; if (m_if.out !== 20'd0) begin n_fail++; $display("FAIL reset_out: got %0d want 0", m_if.out); end
    n_tests++; if (m_if.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", m_if.ovf); end
    clr = 0;
    tick;
  endtask

  task automatic test_unsigned;
    int lat;
    run_main(8'd13, 8'd11, 1'b0, lat);
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL uns_latency: got %0d want 9", lat); end
    n_tests++; if (m_if.out !== 20'd143) begin n_fail++; $display("FAIL uns_13x11: got %0d want 143", m_if.out); end
    tick;
    n_tests++; if (m_if.done !== 1'b0) begin n_fail++; $display("FAIL uns_done_pulse: got %b want 0", m_if.done); end
    run_main(8'd255, 8'd255, 1'b0, lat);
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL uns_latency2: got %0d want 9", lat); end
    n_tests++; if (m_if.out !== 20'd65168) begin n_fail++; $display("FAIL uns_255x255: got %0d want 65168", m_if.out); end
    n_tests++; if (m_if.ovf !== 1'b0) begin n_fail++; $display("FAIL uns_ovf: got %b want 0", m_if.ovf); end
  endtask

  task automatic test_clr_midrun;
    int dones;
    m_if.start = 1; m_if.opa = 8'd5; m_if.opb = 8'd5; m_if.signed_mode = 0;
    tick;
    m_if.start = 0;
    tick; tick;
    #2 clr = 1;
    #1;
    n_tests++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b want 0", m_if.busy); end
    n_tests++; if (m_if.done !== 1'b0) begin n_fail++; $display("FAIL clr_done: got %b want 0", m_if.done); end
    n_tests++; if (m_if.out !== 20'd0) begin n_fail++; $display("FAIL clr_out: got %0d want 0", m_if.out); end
    n_tests++; if (m_if.ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", m_if.ovf); end
    #2 clr = 0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (m_if.done) dones++;
    end
    n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL clr_no_done: got %0d pulses want 0", dones); end
    n_tests++; if (m_if.out !== 20'd0) begin n_fail++; $display("FAIL clr_out_after: got %0d want 0", m_if.out); end
  endtask

  task automatic test_signed;
    int lat;
    run_main(8'hFD, 8'h07, 1'b1, lat);
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL sgn_latency: got %0d want 9", lat); end
    n_tests++; if (m_if.out !== 20'hFFFEB) begin n_fail++; $display("FAIL sgn_m3x7: got %h want FFFEB", m_if.out); end
    run_main(8'h80, 8'h80, 1'b1, lat);
    n_tests++; if (m_if.out !== 20'd16363) begin n_fail++; $display("FAIL sgn_m128sq: got %0d want 16363", m_if.out); end
    n_tests++; if (m_if.ovf !== 1'b0) begin n_fail++; $display("FAIL sgn_ovf: got %b want 0", m_if.ovf); end
  endtask

  task automatic test_overflow16;
    int lat;
    run_16(8'd255, 8'd255, lat);
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL ov16_latency: got %0d want 9", lat); end
    n_tests++; if (s_if.out !== 16'd65025) begin n_fail++; $display("FAIL ov16_sat_first: got %0d want 65025", s_if.out); end
    n_tests++; if (w_if.ovf !== 1'b0) begin n_fail++; $display("FAIL ov16_wrap_first_ovf: got %b want 0", w_if.ovf); end
    run_16(8'd255, 8'd255, lat);
    n_tests++; if (s_if.out !== 16'hFFFF) begin n_fail++; $display("FAIL ov16_sat_out: got %h want FFFF", s_if.out); end
    n_tests++; if (s_if.ovf !== 1'b1) begin n_fail++; $display("FAIL ov16_sat_ovf: got %b want 1", s_if.ovf); end
    n_tests++; if (w_if.out !== 16'd64514) begin n_fail++; $display("FAIL ov16_wrap_out: got %0d want 64514", w_if.out); end
    n_tests++; if (w_if.ovf !== 1'b1) begin n_fail++; $display("FAIL ov16_wrap_ovf: got %b want 1", w_if.ovf); end
    tick; tick;
    n_tests++; if (s_if.ovf !== 1'b1) begin n_fail++; $display("FAIL ov16_sticky: got %b want 1", s_if.ovf); end
    s_if.acc_clr = 1; w_if.acc_clr = 1;
    tick;
    s_if.acc_clr = 0; w_if.acc_clr = 0;
    n_tests++; if (s_if.out !== 16'd0 || s_if.ovf !== 1'b0) begin n_fail++; $display("FAIL ov16_clr_sat: got out=%0d ovf=%b want 0/0", s_if.out, s_if.ovf); end
    n_tests++; if (w_if.out !== 16'd0 || w_if.ovf !== 1'b0) begin n_fail++; $display("FAIL ov16_clr_wrap: got out=%0d ovf=%b want 0/0", w_if.out, w_if.ovf); end
  endtask

  task automatic test_handshake;
    int dones;
    int lat;
    m_if.acc_clr = 1;
    tick;
    m_if.acc_clr = 0;
    n_tests++; if (m_if.out !== 20'd0) begin n_fail++; $display("FAIL hs_clear: got %0d want 0", m_if.out); end
    m_if.start = 1; m_if.opa = 8'd2; m_if.opb = 8'd3; m_if.signed_mode = 0;
    tick;
    n_tests++; if (m_if.busy !== 1'b1) begin n_fail++; $display("FAIL hs_busy: got %b want 1", m_if.busy); end
    for (int i = 0; i < 4; i++) tick;
    m_if.start = 0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (m_if.done) dones++;
    end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL hs_single_op: got %0d dones want 1", dones); end
    n_tests++; if (m_if.out !== 20'd6) begin n_fail++; $display("FAIL hs_hold_out: got %0d want 6", m_if.out); end
    run_main(8'd2, 8'd3, 1'b0, lat);
    run_main(8'd4, 8'd5, 1'b0, lat);
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL hs_b2b_latency: got %0d want 9", lat); end
    n_tests++; if (m_if.out !== 20'd32) begin n_fail++; $display("FAIL hs_b2b_out: got %0d want 32", m_if.out); end
  endtask

  task automatic test_acc_clr;
    int lat;
    m_if.acc_clr = 1;
    tick;
    m_if.acc_clr = 0;
    run_main(8'd10, 8'd10, 1'b0, lat);
    n_tests++; if (m_if.out !== 20'd100) begin n_fail++; $display("FAIL ac_preload: got %0d want 100", m_if.out); end
    tick;
    m_if.start = 1; m_if.opa = 8'd3; m_if.opb = 8'd4;
    tick;
    m_if.start = 0;
    tick; tick;
    m_if.acc_clr = 1;
    tick;
    m_if.acc_clr = 0;
    n_tests++; if (m_if.out !== 20'd0) begin n_fail++; $display("FAIL ac_run_clear: got %0d want 0", m_if.out); end
    lat = -1;
    for (int i = 4; i <= 20; i++) begin
      tick;
      if (m_if.done) begin lat = i; break; end
    end
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL ac_run_latency: got %0d want 9", lat); end
    n_tests++; if (m_if.out !== 20'd12) begin n_fail++; $display("FAIL ac_run_final: got %0d want 12", m_if.out); end
    m_if.start = 1; m_if.opa = 8'd3; m_if.opb = 8'd4;
    tick;
    m_if.start = 0;
    for (int i = 0; i < 8; i++) tick;
    m_if.acc_clr = 1;
    tick;
    m_if.acc_clr = 0;
    n_tests++; if (m_if.done !== 1'b1) begin n_fail++; $display("FAIL ac_acc_done: got %b want 1", m_if.done); end
    n_tests++; if (m_if.out !== 20'd12) begin n_fail++; $display("FAIL ac_acc_load: got %0d want 12", m_if.out); end
    n_tests++; if (m_if.ovf !== 1'b0) begin n_fail++; $display("FAIL ac_acc_ovf: got %b want 0", m_if.ovf); end
  endtask

  initial begin
    clr = 1;
    drive_idle();
    test_reset();
    test_unsigned();
    test_clr_midrun();
    test_signed();
    test_overflow16();
    test_handshake();
    test_acc_clr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
